hdmi_pattern_gen: RTL and testbench
===================================

Name: hdmi_pattern_gen

Overview:
- Parametrised multi-mode video test-pattern generator for the pixel clock domain. It replaces the single hard-wired grid/ramp pattern in HDMI top levels.
- Sits between the HDMI core's raster position outputs (xpixel, ypixel, vblank) and its red/grn/blu inputs.
- Produces a checkerboard/ramp, SMPTE-order colour bars, a solid colour, or an animated scrolling gradient.
- Mode and solid colour change only at frame boundaries.

Parameters:
- HWIDTH, 960, active pixels per line
- VHEIGHT, 600, active lines per frame
- XYW, 11, width of xpixel/ypixel
- CW, 8, bits per colour channel (CW >= 4)
- CHECK_LOG2, 3, checker square size = 2**CHECK_LOG2 pixels
- FRAME_W, 8, frame counter width

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- xpixel  in  XYW  current pixel column from HDMI core
- ypixel  in  XYW  current pixel row from HDMI core
- vblank  in  1  vertical blanking flag from HDMI core
- mode  in  2  requested pattern: 0 checker, 1 bars, 2 solid, 3 gradient
- solid_color  in  3*CW  {R,G,B} for mode 2
- red  out  CW  red channel
- grn  out  CW  green channel
- blu  out  CW  blue channel
- de  out  1  active-area flag aligned with rgb
- frame  out  FRAME_W  frame counter

Behaviour:
- Reset (async assert, sync release): red/grn/blu=0, de=0, frame=0, mode_q=0, color_q=0, vblank_d=0, pipeline registers=0.
- vblank_d <= vblank each cycle. frame_start = vblank & ~vblank_d.
- On frame_start: mode_q <= mode; color_q <= solid_color; frame <= frame+1 (wraps 2**FRAME_W-1 -> 0).
- Mode and colour changes mid-frame are ignored until the next frame_start. A vblank already high at reset release produces no frame_start.
- Stage 1 registers the following:
  - x1, y1
  - act1 = (xpixel < HWIDTH) & (ypixel < VHEIGHT)
  - bar1 = 3-bit index from 7 constant compares of xpixel against k*(HWIDTH/8), k=1..7 (no divider)
- Stage 2 registers red/grn/blu/de. de = act1. When act1=0, rgb=0.
- Latency: 2 clk from xpixel/ypixel to rgb/de.
- Mode 0 (checker):
  - red = x1[CHECK_LOG2] ? all-ones : 0
  - grn = y1[CHECK_LOG2] ? all-ones : 0
  - blu = y1[CW-1:0]
- Mode 1 (bars), index i = bar1:
  - R = ~i[1], G = ~i[2], B = ~i[0], each channel all-ones or 0
  - Order: white, yellow, cyan, green, magenta, red, blue, black
- Mode 2 (solid): rgb = color_q.
- Mode 3 (gradient), all sums truncated to CW bits:
  - red = x1 + frame
  - grn = y1 + frame
  - blu = x1 + y1
  - frame is zero-extended or truncated to CW.
- The frame value used in stage 2 is the registered frame. A frame_start on the same cycle uses the old value.
- X/Y jumps (non-monotonic input) need no special handling. The output is purely a function of the sampled coordinates.

Optional Feature:
- Macro: HDMI_PATTERN_GEN_BORDER_EN.
- Defined: in any mode, an active pixel with x1==0, x1==HWIDTH-1, y1==0 or y1==VHEIGHT-1 outputs all-ones on all channels (1-pixel white border). Latency is unchanged.
- Undefined: no border logic; mode output only.

Test Plan:
- Mode 0, x=8, y=3 -> 2 clk later red=FF, grn=00, blu=03, de=1. x=960, y=0 -> rgb=0, de=0.
- Mode 1, HWIDTH=960, x=0/120/359/840 -> FFFFFF / FFFF00 / 00FFFF / 000000 (RGB), checked at 2-clk latency.
- Mode held 0, mode set to 2 mid-frame with solid_color=123456 -> output stays checker until next vblank rising edge, then rgb=12,34,56 in the following active area.
- Mode 3, run 256 vblank pulses -> frame increments per rising edge and wraps FF->00. At frame=05, x=10, y=20 -> red=0F, grn=19, blu=1E.
- Assert rst_n low mid-line -> rgb, de and frame are 0 immediately (async). After release with vblank high -> frame stays 0 until vblank falls and rises again.
- With HDMI_PATTERN_GEN_BORDER_EN, mode 2 colour 000000: x=0 or x=959 or y=599 -> FFFFFF; x=1, y=1 -> 000000. Without the macro -> 000000 everywhere.

Source files
------------

// File: rtl/hdmi_pattern_gen.sv
// hdmi_pattern_gen: multi-mode video test-pattern generator (pixel clock domain).
// Modes: 0 checker/ramp, 1 colour bars, 2 solid colour, 3 scrolling gradient.
// Mode and solid colour are latched at the vblank rising edge.
// Optional 1-pixel white border: define HDMI_PATTERN_GEN_BORDER_EN.
module hdmi_pattern_gen #(
    parameter int unsigned HWIDTH     = 960,
    parameter int unsigned VHEIGHT    = 600,
    parameter int unsigned XYW        = 11,
    parameter int unsigned CW         = 8,
    parameter int unsigned CHECK_LOG2 = 3,
    parameter int unsigned FRAME_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [XYW-1:0]     xpixel,
    input  logic [XYW-1:0]     ypixel,
    input  logic               vblank,
    input  logic [1:0]         mode,
    input  logic [3*CW-1:0]    solid_color,
    output logic [CW-1:0]      red,
    output logic [CW-1:0]      grn,
    output logic [CW-1:0]      blu,
    output logic               de,
    output logic [FRAME_W-1:0] frame
);

    localparam int unsigned BAR_W = HWIDTH / 8;
    localparam logic [CW-1:0] ONES = {CW{1'b1}};

    logic              vblank_d;
    logic              primed;
    logic              frame_start;
    logic [1:0]        mode_q;
    logic [3*CW-1:0]   color_q;
    logic [XYW-1:0]    x1;
    logic [XYW-1:0]    y1;
    logic              act1;
    logic [2:0]        bar1;
    logic [2:0]        bar_c;
    logic              act_c;
    logic [CW-1:0]     frame_cw;
    logic [CW-1:0]     r_c;
    logic [CW-1:0]     g_c;
    logic [CW-1:0]     b_c;

    // A rising edge needs a real low sample after reset, so a vblank already
    // high at release is not mistaken for a frame start.
    assign frame_start = vblank & ~vblank_d & primed;
    assign act_c       = (xpixel < XYW'(HWIDTH)) & (ypixel < XYW'(VHEIGHT));
    assign frame_cw    = CW'(frame);

    // Bar index from ascending constant thresholds; the highest one passed wins.
    always_comb begin
        bar_c = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (xpixel >= XYW'(k * BAR_W)) begin
                bar_c = 3'(k);
            end
        end
    end

    // Frame-boundary control: edge detect, mode/colour latch, frame counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vblank_d <= 1'b0;
            primed   <= 1'b0;
            mode_q   <= 2'd0;
            color_q  <= '0;
            frame    <= '0;
        end else begin
            vblank_d <= vblank;
            primed   <= 1'b1;
            if (frame_start) begin
                mode_q  <= mode;
                color_q <= solid_color;
                frame   <= frame + FRAME_W'(1);
            end
        end
    end

    // Stage 1: sample coordinates, active flag and bar index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x1   <= '0;
            y1   <= '0;
            act1 <= 1'b0;
            bar1 <= 3'd0;
        end else begin
            x1   <= xpixel;
            y1   <= ypixel;
            act1 <= act_c;
            bar1 <= bar_c;
        end
    end

    // Pattern select from stage-1 values and the currently latched mode.
    always_comb begin
        r_c = '0;
        g_c = '0;
        b_c = '0;
        case (mode_q)
            2'd0: begin
                r_c = x1[CHECK_LOG2] ? ONES : '0;
                g_c = y1[CHECK_LOG2] ? ONES : '0;
                b_c = CW'(y1);
            end
            2'd1: begin
                r_c = bar1[1] ? '0 : ONES;
                g_c = bar1[2] ? '0 : ONES;
                b_c = bar1[0] ? '0 : ONES;
            end
            2'd2: begin
                r_c = color_q[3*CW-1 -: CW];
                g_c = color_q[2*CW-1 -: CW];
                b_c = color_q[CW-1:0];
            end
            default: begin
                r_c = CW'(x1) + frame_cw;
                g_c = CW'(y1) + frame_cw;
                b_c = CW'(x1) + CW'(y1);
            end
        endcase
`ifdef HDMI_PATTERN_GEN_BORDER_EN
        if ((x1 == '0) || (x1 == XYW'(HWIDTH - 1)) ||
            (y1 == '0) || (y1 == XYW'(VHEIGHT - 1))) begin
            r_c = ONES;
            g_c = ONES;
            b_c = ONES;
        end
`endif
        if (!act1) begin
            r_c = '0;
            g_c = '0;
            b_c = '0;
        end
    end

    // Stage 2: registered colour outputs and data-enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            red <= '0;
            grn <= '0;
            blu <= '0;
            de  <= 1'b0;
        end else begin
            red <= r_c;
            grn <= g_c;
            blu <= b_c;
            de  <= act1;
        end
    end

endmodule

// File: tb/tb_hdmi_pattern_gen.sv
// Self-checking bench for hdmi_pattern_gen: behavioural model plus directed literals.
module tb_hdmi_pattern_gen;

    localparam int HW = 960;
    localparam int VH = 600;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] xpixel = '0;
    logic [10:0] ypixel = '0;
    logic        vblank = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [23:0] solid_color = '0;
    logic [7:0]  red, grn, blu, frame;
    logic        de;

    int total = 0;
    int bad = 0;
    int npulse = 0;

    hdmi_pattern_gen dut (
        .clk(clk), .rst_n(rst_n), .xpixel(xpixel), .ypixel(ypixel),
        .vblank(vblank), .mode(mode), .solid_color(solid_color),
        .red(red), .grn(grn), .blu(blu), .de(de), .frame(frame)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, got, want, $time);
        end
    endtask

    // Expected pixel for a coordinate from the pattern rules.
    function automatic logic [23:0] pix(int x, int y, int m, logic [23:0] c, int f);
        logic [23:0] p;
        case (m)
            0: p = {((x / 8) % 2 == 1) ? 8'hFF : 8'h00,
                    ((y / 8) % 2 == 1) ? 8'hFF : 8'h00, 8'(y % 256)};
            1: case (x / (HW / 8))
                   0: p = 24'hFFFFFF; 1: p = 24'hFFFF00; 2: p = 24'h00FFFF;
                   3: p = 24'h00FF00; 4: p = 24'hFF00FF; 5: p = 24'hFF0000;
                   6: p = 24'h0000FF; default: p = 24'h000000;
               endcase
            2: p = c;
            default: p = {8'((x + f) % 256), 8'((y + f) % 256), 8'((x + y) % 256)};
        endcase
`ifdef HDMI_PATTERN_GEN_BORDER_EN
        if (x == 0 || x == HW - 1 || y == 0 || y == VH - 1) p = 24'hFFFFFF;
`endif
        return p;
    endfunction

    // Reference model: previous-cycle sample, latched mode/colour, frame count.
    int          sx, sy, m_mode, m_frame;
    bit          sact, prev_ok, prev_vb;
    logic [23:0] m_col;
    logic [32:0] exp_v;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sx = 0; sy = 0; sact = 0; m_mode = 0; m_col = '0; m_frame = 0;
            prev_ok = 0; prev_vb = 0; exp_v = '0;
        end else begin
            exp_v[32:9] = sact ? pix(sx, sy, m_mode, m_col, m_frame) : 24'h0;
            exp_v[8]    = sact;
            if (prev_ok && vblank && !prev_vb) begin
                m_mode  = int'(mode);
                m_col   = solid_color;
                m_frame = (m_frame + 1) % 256;
            end
            exp_v[7:0] = 8'(m_frame);
            prev_vb = vblank;
            prev_ok = 1;
            sx = int'(xpixel);
            sy = int'(ypixel);
            sact = (sx < HW) && (sy < VH);
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        chk("cycle", {31'b0, red, grn, blu, de, frame}, {31'b0, exp_v});
    end

    task automatic sample(input int x, input int y);
        @(negedge clk);
        xpixel = 11'(x);
        ypixel = 11'(y);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic pulse();
        @(negedge clk);
        vblank = 1'b1;
        @(negedge clk);
        vblank = 1'b0;
        npulse++;
    endtask

    function automatic logic [23:0] bdr(logic [23:0] plain);
`ifdef HDMI_PATTERN_GEN_BORDER_EN
        return 24'hFFFFFF;
`else
        return plain;
`endif
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_out", {red, grn, blu, de, frame}, 33'h0);
        rst_n = 1'b1;

        sample(8, 3);
        chk("chk_8_3", {red, grn, blu, de}, {24'hFF0003, 1'b1});
        sample(960, 0);
        chk("chk_inactive", {red, grn, blu, de}, 25'h0);

        mode = 2'd2;
        solid_color = 24'h123456;
        sample(8, 3);
        chk("mode_hold", {red, grn, blu}, 24'hFF0003);
        pulse();
        sample(1, 1);
        chk("solid", {red, grn, blu}, 24'h123456);

        mode = 2'd1;
        pulse();
        sample(0, 100);   chk("bar_0",   {red, grn, blu}, 24'hFFFFFF);
        sample(120, 100); chk("bar_120", {red, grn, blu}, 24'hFFFF00);
        sample(359, 100); chk("bar_359", {red, grn, blu}, 24'h00FFFF);
        sample(840, 100); chk("bar_840", {red, grn, blu}, 24'h000000);

        mode = 2'd2;
        solid_color = 24'h000000;
        pulse();
        sample(0, 100);   chk("bdr_x0",   {red, grn, blu}, bdr(24'h0));
        sample(959, 100); chk("bdr_x959", {red, grn, blu}, bdr(24'h0));
        sample(500, 599); chk("bdr_y599", {red, grn, blu}, bdr(24'h0));
        sample(1, 1);     chk("bdr_in",   {red, grn, blu}, 24'h000000);

        mode = 2'd3;
        while (npulse % 256 != 5) pulse();
        chk("frame5", {24'h0, frame}, 32'h5);
        sample(10, 20);
        chk("grad", {red, grn, blu}, 24'h0F191E);
        while (npulse % 256 != 255) pulse();
        chk("frame_ff", {24'h0, frame}, 32'hFF);
        pulse();
        chk("frame_wrap", {24'h0, frame}, 32'h0);

        // Random raster with edge-heavy coordinates.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            case ($urandom_range(0, 5))
                0: xpixel = 11'($urandom_range(958, 961));
                default: xpixel = 11'($urandom_range(0, 1100));
            endcase
            case ($urandom_range(0, 5))
                0: ypixel = 11'($urandom_range(598, 601));
                default: ypixel = 11'($urandom_range(0, 700));
            endcase
            vblank = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) solid_color = 24'($urandom);
        end

        // Mid-line async reset, then release with vblank already high.
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk("async_rst", {red, grn, blu, de, frame}, 33'h0);
        @(negedge clk);
        vblank = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("vb_high_release", {24'h0, frame}, 32'h0);
        vblank = 1'b0;
        @(negedge clk);
        vblank = 1'b1;
        @(negedge clk);
        chk("first_edge", {24'h0, frame}, 32'h1);
        vblank = 1'b0;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
